// File: rtl/mult25x18_parallel_pipe_core.sv
// Unsigned 25x18 multiplier with a full-precision 43-bit product.
// Operands are registered, expanded into 18 shifted partial products and
// summed through a registered binary adder tree (18 -> 9 -> 5 -> 3 -> 2 -> 1).
// A new pair is accepted every clock; the product appears on PROD_OUT after
// the fifth edge following capture. There is no enable and no valid flag.
module mult25x18_parallel_pipe_core (
  input  logic        CLK,
  input  logic        RST,
  input  logic [24:0] A_IN,
  input  logic [17:0] B_IN,
  output logic [42:0] PROD_OUT
);

  localparam int unsigned PW = 43;

  // S0 operand registers
  logic [24:0]   a_q;
  logic [17:0]   b_q;

  // Partial products formed from the S0 registers
  logic [PW-1:0] pp [18];

  // Adder tree registers; each level holds ceil(n/2) sums of the level above
  logic [PW-1:0] s1_sum [9];
  logic [PW-1:0] s2_sum [5];
  logic [PW-1:0] s3_sum [3];
  logic [PW-1:0] s4_sum [2];

  // S0: capture the operand pair
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the values from before the edge.
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= A_IN;
      b_q <= B_IN;
    end
  end

  // Partial products: A shifted by the bit position of each set B bit
  always_comb begin
    for (int i = 0; i < 18; i++) begin
      // NOTE: every element gets a value on every path, so no latch is inferred.
      pp[i] = b_q[i] ? ({18'd0, a_q} << i) : '0;
    end
  end

  // S1: add adjacent partial-product pairs into 9 sums
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: these arrays are pipeline state, not storage, so they are cleared
      // in full; that is what guarantees no in-flight product survives a reset.
      for (int j = 0; j < 9; j++) s1_sum[j] <= '0;
    end else begin
      for (int j = 0; j < 9; j++) s1_sum[j] <= pp[2*j] + pp[2*j+1];
    end
  end

  // S2: 9 -> 5, the ninth sum passes through
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int j = 0; j < 5; j++) s2_sum[j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++) s2_sum[j] <= s1_sum[2*j] + s1_sum[2*j+1];
      s2_sum[4] <= s1_sum[8];
    end
  end

  // S3: 5 -> 3, the fifth sum passes through
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int j = 0; j < 3; j++) s3_sum[j] <= '0;
    end else begin
      s3_sum[0] <= s2_sum[0] + s2_sum[1];
      s3_sum[1] <= s2_sum[2] + s2_sum[3];
      s3_sum[2] <= s2_sum[4];
    end
  end

  // S4: 3 -> 2, the third sum passes through
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s4_sum[0] <= '0;
      s4_sum[1] <= '0;
    end else begin
      s4_sum[0] <= s3_sum[0] + s3_sum[1];
      s4_sum[1] <= s3_sum[2];
    end
  end

  // S5: final sum registered as the product. The true product never exceeds
  // 2^43 - 1, so no carry out of bit 42 can occur at any level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) PROD_OUT <= '0;
    else     PROD_OUT <= s4_sum[0] + s4_sum[1];
  end

endmodule

// File: tb/tb_mult25x18_parallel_pipe_core.sv
// Directed bench for mult25x18_parallel_pipe_core. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_mult25x18_parallel_pipe_core;

  logic        CLK = 1'b0;
  logic        RST;
  logic [24:0] A_IN;
  logic [17:0] B_IN;
  logic [42:0] PROD_OUT;

  int total = 0;
  int bad   = 0;

  mult25x18_parallel_pipe_core dut (
    .CLK      (CLK),
    .RST      (RST),
    .A_IN     (A_IN),
    .B_IN     (B_IN),
    .PROD_OUT (PROD_OUT)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST  = 1'b1;
    A_IN = 'x;
    B_IN = 'x;
    #2;
    total++;
    if (PROD_OUT !== 43'd0) begin
      bad++;
      $display("FAIL reset_async: got %h want %h", PROD_OUT, 43'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (PROD_OUT !== 43'd0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, PROD_OUT, 43'd0);
      end
    end
  endtask

  task automatic test_hold_512();
    RST  = 1'b0;
    A_IN = 25'd512;
    B_IN = 18'd512;
    // capture edge plus four more: output must remain 0
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (PROD_OUT !== 43'd0) begin
        bad++;
        $display("FAIL fill_zero[%0d]: got %h want %h", i, PROD_OUT, 43'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (PROD_OUT !== 43'h00000040000) begin
        bad++;
        $display("FAIL hold_512[%0d]: got %h want %h", i, PROD_OUT, 43'h00000040000);
      end
    end
  endtask

  task automatic test_change_2020();
    A_IN = 25'd2020;
    B_IN = 18'd2020;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (PROD_OUT !== 43'h00000040000) begin
        bad++;
        $display("FAIL old_held[%0d]: got %h want %h", i, PROD_OUT, 43'h00000040000);
      end
    end
    tick();
    total++;
    if (PROD_OUT !== 43'h0000003E4310) begin
      bad++;
      $display("FAIL prod_2020: got %h want %h", PROD_OUT, 43'h0000003E4310);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] av [5];
    logic [17:0] bv [5];
    logic [42:0] ev [5];
    av[0] = 25'd16777215; bv[0] = 18'd100000; ev[0] = 43'h1869FFE7960;
    av[1] = 25'd1115;     bv[1] = 18'd1115;   ev[1] = 43'h0000012F859;
    av[2] = 25'h1FFFFFF;  bv[2] = 18'h3FFFF;  ev[2] = 43'h7FFFDFC0001;
    av[3] = 25'h1FFFFFF;  bv[3] = 18'd1;      ev[3] = 43'h00001FFFFFF;
    av[4] = 25'd0;        bv[4] = 18'h3FFFF;  ev[4] = 43'd0;
    // one new pair per cycle; pair n is captured on tick n and visible after tick n+5
    for (int n = 0; n < 10; n++) begin
      if (n < 5) begin
        A_IN = av[n];
        B_IN = bv[n];
      end
      tick();
      if (n >= 5) begin
        total++;
        if (PROD_OUT !== ev[n-5]) begin
          bad++;
          $display("FAIL b2b[%0d]: got %h want %h", n-5, PROD_OUT, ev[n-5]);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [42:0] q [$];
    logic [42:0] exp_v;
    logic [24:0] a;
    logic [17:0] b;
    int          errs = 0;
    for (int c = 0; c < 1005; c++) begin
      a = 25'($urandom);
      b = 18'($urandom);
      A_IN = a;
      B_IN = b;
      tick();
      q.push_back(43'(64'(a) * 64'(b)));
      if (q.size() == 6) begin
        exp_v = q.pop_front();
        total++;
        if (PROD_OUT !== exp_v) begin
          bad++;
          errs++;
          if (errs <= 5)
            $display("FAIL stream[%0d]: got %h want %h", c, PROD_OUT, exp_v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // pipeline is full from streaming; assert reset between edges
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    total++;
    if (PROD_OUT !== 43'd0) begin
      bad++;
      $display("FAIL mid_reset: got %h want %h", PROD_OUT, 43'd0);
    end
    tick();
    tick();
    RST  = 1'b0;
    A_IN = 25'd1115;
    B_IN = 18'd1115;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (PROD_OUT !== 43'd0) begin
        bad++;
        $display("FAIL no_stale[%0d]: got %h want %h", i, PROD_OUT, 43'd0);
      end
    end
    tick();
    total++;
    if (PROD_OUT !== 43'h0000012F859) begin
      bad++;
      $display("FAIL post_reset: got %h want %h", PROD_OUT, 43'h0000012F859);
    end
  endtask

  initial begin
    test_reset();
    test_hold_512();
    test_change_2020();
    test_back_to_back();
    test_stream();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
